// File: rtl/pipe_pkg.sv
// Shared types and default widths for the elastic pipeline-stage register.
package pipe_pkg;

  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned DEF_CTRL_W = 2;
  localparam int unsigned DEF_RD_W   = 5;
  localparam int unsigned DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stageStateT;

  // Number of valid entries held in a given state.
  function automatic logic [1:0] heldCount(input stageStateT s);
    case (s)
      ONE:     heldCount = 2'd1;
      TWO:     heldCount = 2'd2;
      default: heldCount = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating event counter with synchronous clear; adds 0..2 per cycle.
module pipe_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic [1:0]   inc,
  output logic [W-1:0] count
);

  localparam int unsigned SW = W + 1;

  logic [W:0] sum;

  // Top bit of the widened sum flags wrap past all-ones.
  assign sum = {1'b0, count} + SW'(inc);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (sum[W]) begin
      count <= '1;
    end else begin
      count <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic two-entry (main + skid) pipeline-stage register with registered in_ready.
// Optional statistics counters are built when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned RD_W   = DEF_RD_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [RD_W-1:0]   out_rd,
  output logic [CNT_W-1:0]  stat_xfer,
  output logic [CNT_W-1:0]  stat_stall,
  output logic [CNT_W-1:0]  stat_flush
);

  stageStateT state, stateNext;

  logic              inReadyQ, inReadyNext;
  logic              outValidQ, outValidNext;
  logic [DATA_W-1:0] mainData, mainDataNext, skidData, skidDataNext;
  logic [CTRL_W-1:0] mainCtrl, mainCtrlNext, skidCtrl, skidCtrlNext;
  logic [RD_W-1:0]   mainRd, mainRdNext, skidRd, skidRdNext;
  logic              acc, dq;

  assign acc = in_valid && inReadyQ;
  assign dq  = outValidQ && out_ready;

  // State and storage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      inReadyQ  <= 1'b1;
      outValidQ <= 1'b0;
      mainData  <= '0;
      mainCtrl  <= '0;
      mainRd    <= '0;
      skidData  <= '0;
      skidCtrl  <= '0;
      skidRd    <= '0;
    end else begin
      state     <= stateNext;
      inReadyQ  <= inReadyNext;
      outValidQ <= outValidNext;
      mainData  <= mainDataNext;
      mainCtrl  <= mainCtrlNext;
      mainRd    <= mainRdNext;
      skidData  <= skidDataNext;
      skidCtrl  <= skidCtrlNext;
      skidRd    <= skidRdNext;
    end
  end

  // Next-state and next-storage logic; flush overrides every handshake.
  always_comb begin
    stateNext    = state;
    mainDataNext = mainData;
    mainCtrlNext = mainCtrl;
    mainRdNext   = mainRd;
    skidDataNext = skidData;
    skidCtrlNext = skidCtrl;
    skidRdNext   = skidRd;

    case (state)
      EMPTY: begin
        if (acc) begin
          mainDataNext = in_data;
          mainCtrlNext = in_ctrl;
          mainRdNext   = in_rd;
          stateNext    = ONE;
        end
      end
      ONE: begin
        if (acc && !dq) begin
          skidDataNext = in_data;
          skidCtrlNext = in_ctrl;
          skidRdNext   = in_rd;
          stateNext    = TWO;
        end else if (acc && dq) begin
          mainDataNext = in_data;
          mainCtrlNext = in_ctrl;
          mainRdNext   = in_rd;
        end else if (dq) begin
          // Emptied stage presents a bubble with zero control.
          mainDataNext = '0;
          mainCtrlNext = '0;
          mainRdNext   = '0;
          stateNext    = EMPTY;
        end
      end
      TWO: begin
        if (dq) begin
          mainDataNext = skidData;
          mainCtrlNext = skidCtrl;
          mainRdNext   = skidRd;
          stateNext    = ONE;
        end
      end
      default: begin
        stateNext = EMPTY;
      end
    endcase

    if (flush) begin
      stateNext    = EMPTY;
      mainDataNext = '0;
      mainCtrlNext = '0;
      mainRdNext   = '0;
      skidDataNext = '0;
      skidCtrlNext = '0;
      skidRdNext   = '0;
    end

    outValidNext = (stateNext != EMPTY);
    inReadyNext  = (stateNext != TWO);
  end

  assign in_ready  = inReadyQ;
  assign out_valid = outValidQ;
  assign out_data  = mainData;
  assign out_ctrl  = mainCtrl;
  assign out_rd    = mainRd;

`ifdef PIPE_STAGE_STATS_EN
  logic [1:0] flushAmt;

  // Entries lost to flush: held ones not dequeued, plus a beat accepted this cycle.
  always_comb begin
    flushAmt = 2'd0;
    if (flush) begin
      flushAmt = 2'(heldCount(state) - {1'b0, dq} + {1'b0, acc});
    end
  end

  pipe_sat_cnt #(.W(CNT_W)) xferCnt (
    .clk   (clk),
    .clear (rst),
    .inc   ({1'b0, dq}),
    .count (stat_xfer)
  );

  pipe_sat_cnt #(.W(CNT_W)) stallCnt (
    .clk   (clk),
    .clear (rst),
    .inc   ({1'b0, outValidQ && !out_ready}),
    .count (stat_stall)
  );

  pipe_sat_cnt #(.W(CNT_W)) flushCnt (
    .clk   (clk),
    .clear (rst),
    .inc   (flushAmt),
    .count (stat_flush)
  );
`else
  assign stat_xfer  = '0;
  assign stat_stall = '0;
  assign stat_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed table-driven bench for pipe_stage_reg plus an ordered-stream scoreboard run.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, inValid, inReady, outValid, outReady;
  logic [63:0] inData, outData;
  logic [1:0]  inCtrl, outCtrl;
  logic [4:0]  inRd, outRd;
  logic [15:0] statXfer, statStall, statFlush;

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .in_data    (inData),
    .in_ctrl    (inCtrl),
    .in_rd      (inRd),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_data   (outData),
    .out_ctrl   (outCtrl),
    .out_rd     (outRd),
    .stat_xfer  (statXfer),
    .stat_stall (statStall),
    .stat_flush (statFlush)
  );

  typedef struct {
    logic        rst, flush, inValid;
    logic [63:0] inData;
    logic [1:0]  inCtrl;
    logic [4:0]  inRd;
    logic        outReady;
    logic        eReady, eValid;
    logic [63:0] eData;
    logic [1:0]  eCtrl;
    logic [4:0]  eRd;
    logic        dCare;
    int          eXfer, eStall, eFlush;
  } vecT;

  vecT vecs[$];

  function automatic vecT mk(input logic r, input logic f, input logic iv, input logic [63:0] d,
                             input logic [1:0] c, input logic [4:0] rd, input logic ordy,
                             input logic eRdy, input logic eVal, input logic [63:0] eD,
                             input logic [1:0] eC, input logic [4:0] eR, input logic care,
                             input int x, input int s, input int fl);
    vecT v;
    v.rst = r; v.flush = f; v.inValid = iv; v.inData = d; v.inCtrl = c; v.inRd = rd;
    v.outReady = ordy; v.eReady = eRdy; v.eValid = eVal; v.eData = eD; v.eCtrl = eC;
    v.eRd = eR; v.dCare = care; v.eXfer = x; v.eStall = s; v.eFlush = fl;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] statExp(input int n);
    return STATS ? 16'(n) : 16'd0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [72:0] gotRow, expRow;
    logic [70:0] expQ[$];
    logic [70:0] front;
    int sent, got, cyc;

    rst = 1'b1; flush = 1'b0; inValid = 1'b0; inData = '0; inCtrl = '0; inRd = '0;
    outReady = 1'b0;

    // rst flush iv data ctrl rd ordy | rdy val data ctrl rd care | xfer stall flush
    vecs.push_back(mk(1,0,0,64'h0,2'd0,5'd0,0, 1,0,64'h0,2'd0,5'd0,1, 0,0,0));
    vecs.push_back(mk(1,0,0,64'h0,2'd0,5'd0,0, 1,0,64'h0,2'd0,5'd0,1, 0,0,0));
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(0,0,1,64'(i),2'b01,5'(4+i),1, 1,1,64'(i),2'b01,5'(4+i),1, i-1,0,0));
    vecs.push_back(mk(0,0,0,64'h0,2'd0,5'd0,1, 1,0,64'h0,2'd0,5'd0,0, 8,0,0));
    // Backpressure: A, B fill the stage, C is refused, then drain.
    vecs.push_back(mk(0,0,1,64'hA,2'd2,5'd3,0, 1,1,64'hA,2'd2,5'd3,1, 8,0,0));
    vecs.push_back(mk(0,0,1,64'hB,2'd3,5'd7,0, 0,1,64'hA,2'd2,5'd3,1, 8,1,0));
    vecs.push_back(mk(0,0,1,64'hC,2'd1,5'd1,0, 0,1,64'hA,2'd2,5'd3,1, 8,2,0));
    vecs.push_back(mk(0,0,0,64'h0,2'd0,5'd0,1, 1,1,64'hB,2'd3,5'd7,1, 9,2,0));
    vecs.push_back(mk(0,0,0,64'h0,2'd0,5'd0,1, 1,0,64'h0,2'd0,5'd0,0, 10,2,0));
    // Flush in TWO with a beat offered.
    vecs.push_back(mk(0,0,1,64'h11,2'd1,5'd2,0, 1,1,64'h11,2'd1,5'd2,1, 10,2,0));
    vecs.push_back(mk(0,0,1,64'h22,2'd2,5'd4,0, 0,1,64'h11,2'd1,5'd2,1, 10,3,0));
    vecs.push_back(mk(0,1,1,64'h33,2'd3,5'd6,0, 1,0,64'h0,2'd0,5'd0,1, 10,4,2));
    // Flush in ONE with dequeue and accept in the same cycle.
    vecs.push_back(mk(0,0,1,64'hE,2'd1,5'd9,0, 1,1,64'hE,2'd1,5'd9,1, 10,4,2));
    vecs.push_back(mk(0,1,1,64'hF,2'd3,5'd10,1, 1,0,64'h0,2'd0,5'd0,1, 11,4,3));
    vecs.push_back(mk(0,0,0,64'h0,2'd0,5'd0,1, 1,0,64'h0,2'd0,5'd0,0, 11,4,3));
    // rst together with flush while full.
    vecs.push_back(mk(0,0,1,64'h44,2'd2,5'd11,0, 1,1,64'h44,2'd2,5'd11,1, 11,4,3));
    vecs.push_back(mk(0,0,1,64'h55,2'd1,5'd12,0, 0,1,64'h44,2'd2,5'd11,1, 11,5,3));
    vecs.push_back(mk(1,1,1,64'h66,2'd1,5'd14,0, 1,0,64'h0,2'd0,5'd0,1, 0,0,0));
    vecs.push_back(mk(0,0,1,64'h77,2'd1,5'd13,1, 1,1,64'h77,2'd1,5'd13,1, 0,0,0));
    vecs.push_back(mk(0,0,0,64'h0,2'd0,5'd0,1, 1,0,64'h0,2'd0,5'd0,0, 1,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; flush = vecs[i].flush; inValid = vecs[i].inValid;
      inData = vecs[i].inData; inCtrl = vecs[i].inCtrl; inRd = vecs[i].inRd;
      outReady = vecs[i].outReady;
      @(posedge clk); #1;
      gotRow = {inReady, outValid, vecs[i].dCare ? outData : 64'h0, outCtrl, outRd};
      expRow = {vecs[i].eReady, vecs[i].eValid, vecs[i].dCare ? vecs[i].eData : 64'h0,
                vecs[i].eCtrl, vecs[i].eRd};
      check($sformatf("row%0d {rdy,val,data,ctrl,rd}", i), 128'(gotRow), 128'(expRow));
      check($sformatf("row%0d stat_xfer", i),  128'(statXfer),  128'(statExp(vecs[i].eXfer)));
      check($sformatf("row%0d stat_stall", i), 128'(statStall), 128'(statExp(vecs[i].eStall)));
      check($sformatf("row%0d stat_flush", i), 128'(statFlush), 128'(statExp(vecs[i].eFlush)));
    end

    // Ordered stream of 20 beats under intermittent backpressure.
    rst = 1'b0; flush = 1'b0;
    sent = 0; got = 0; cyc = 0;
    while (got < 20 && cyc < 200) begin
      inValid  = (sent < 20);
      inData   = 64'(256 + sent);
      inCtrl   = 2'(sent);
      inRd     = 5'(sent);
      outReady = (cyc % 3 != 2);
      if (inValid && inReady) begin
        expQ.push_back({inData, inCtrl, inRd});
        sent++;
      end
      if (outValid && outReady) begin
        front = (expQ.size() > 0) ? expQ.pop_front() : 71'h0;
        check($sformatf("stream beat%0d", got), 128'({outData, outCtrl, outRd}), 128'(front));
        got++;
      end else if (!outValid) begin
        check($sformatf("stream bubble ctrl/rd cyc%0d", cyc), 128'({outCtrl, outRd}), 128'h0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    inValid = 1'b0; outReady = 1'b0;
    check("stream beats delivered", 128'(got), 128'(20));
    check("stream stat_xfer", 128'(statXfer), 128'(statExp(21)));

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic pipeline-stage register: the generalised successor of the fixed inter-stage latches (IF/ID … MEM/WB) in the five-stage core. It carries a data payload, a control vector and a destination-register field between two stages using a valid/ready handshake. It provides full throughput with a registered `in_ready` via a two-entry skid buffer. Flush squashes in-flight entries and forces their control bits to zero, so a bubble can never write the register file or memory.

## Interface
Parameters:
- `DATA_W`, 64: total payload width, e.g. ALU result plus memory read data (2×32).
- `CTRL_W`, 2: control-vector width, e.g. {memtoReg, regWrite}.
- `RD_W`, 5: destination-register index width.
- `CNT_W`, 16: statistics counter width (used only with `PIPE_STAGE_STATS_EN`).

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `flush`, in, 1: squash all held entries; synchronous.
- `in_valid`, in, 1: upstream offers a beat.
- `in_ready`, out, 1: stage accepts a beat; driven directly from a register.
- `in_data`, in, DATA_W: upstream payload.
- `in_ctrl`, in, CTRL_W: upstream control vector.
- `in_rd`, in, RD_W: upstream destination register.
- `out_valid`, out, 1: head entry valid.
- `out_ready`, in, 1: downstream accepts the head entry.
- `out_data`, out, DATA_W: head payload.
- `out_ctrl`, out, CTRL_W: head control; zero whenever `out_valid` = 0.
- `out_rd`, out, RD_W: head destination register; zero whenever `out_valid` = 0.
- `stat_xfer`, out, CNT_W: beats delivered downstream.
- `stat_stall`, out, CNT_W: cycles with `out_valid` && !`out_ready`.
- `stat_flush`, out, CNT_W: entries discarded by flush.

## Operation
- Storage is two entries: main (drives outputs) and skid.
- State machine:
  - EMPTY: no entry held.
  - ONE: main valid.
  - TWO: main and skid valid.
- Handshakes:
  - acc = `in_valid` && `in_ready`.
  - dq = `out_valid` && `out_ready`.
- Transitions:
  - EMPTY: on acc, load main, go to ONE.
  - ONE:
    - acc && !dq: load skid, go to TWO.
    - acc && dq: load main, stay in ONE.
    - !acc && dq: go to EMPTY.
  - TWO:
    - dq: skid moves to main, go to ONE.
    - otherwise hold.
  - acc is impossible in TWO because `in_ready` = 0.
- `in_ready` register is 1 exactly in EMPTY and ONE.
- Flush:
  - Next state is EMPTY and `in_ready` = 1.
  - A beat accepted in the flush cycle is discarded.
  - A dequeue in the flush cycle still completes (the downstream already consumed it).
- Flush also zeroes the `out_data`, `out_ctrl` and `out_rd` registers.
- `rst` has priority over `flush`; `flush` has priority over the handshakes.

## Timing
- Latency: a beat accepted in cycle N is presented with `out_valid` = 1 in cycle N+1.
- Throughput: 1 beat/cycle sustained while `out_ready` = 1.
- `in_ready` deasserts in the cycle after the skid fills. It reasserts in the cycle after a dequeue from TWO.
- Payload is held stable while `out_valid` && !`out_ready`.
- No combinational path from `out_ready` to `in_ready`; outputs are registered.
- Reset values:
  - state = EMPTY.
  - `in_ready` = 1, `out_valid` = 0.
  - `out_data`, `out_ctrl`, `out_rd` all 0.
  - All `stat_*` = 0.
- A reset in the middle of a transfer discards both entries.

## Configuration
- Macro: `PIPE_STAGE_STATS_EN`.
- When defined:
  - `stat_xfer` increments on each dq.
  - `stat_stall` increments each stall cycle.
  - On flush, `stat_flush` increases by the number of valid entries discarded (0, 1 or 2). This count excludes a beat dequeued in the flush cycle but includes a beat accepted in that cycle.
  - All counters saturate at 2^CNT_W − 1.
- When undefined: the `stat_*` ports remain and are tied to 0; no counter flops are synthesised.

## Structure
- Shared package `pipe_pkg` holds:
  - the state enum {EMPTY, ONE, TWO};
  - default widths (`DATA_W`, `CTRL_W`, `RD_W`, `CNT_W`).
- One sub-module `pipe_sat_cnt`: saturating counter with width `CNT_W`, synchronous clear and increment amount 0–2. Instantiated three times under the macro.

## Test plan
- Reset then idle: `rst` for 2 cycles → `in_ready` = 1, `out_valid` = 0, `out_ctrl` = 0, `stat_*` = 0.
- Streaming: 8 beats (`in_data` = 1..8, `in_ctrl` = 2'b01, `in_rd` = 5..12) with `out_ready` = 1 → each appears 1 cycle later, in order, with no gaps; `stat_xfer` = 8.
- Backpressure: `out_ready` = 0 while sending beats A and B → `in_ready` falls after B. Raise `out_ready` → A then B drain; `in_ready` = 1 one cycle after A dequeues; `stat_stall` equals the number of held cycles.
- Flush in TWO with a beat on input: → next cycle `out_valid` = 0, `out_ctrl` = 0, `out_rd` = 0, `in_ready` = 1; `stat_flush` += 2.
- Flush with dq and acc together in ONE: → dequeued beat counted in `stat_xfer`; incoming beat dropped; `stat_flush` += 1.
- `rst` and `flush` asserted with the stage full → reset values; `stat_flush` stays 0.
